// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, round constants,
// key-schedule steps in both directions, and the decryptor FSM state type.
package aes_pkg;

   typedef enum logic [2:0] {IDLE, KEYEXP, ARK0, ROUND, FINAL, DONE} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // NOTE: blocking assignments are correct inside functions and always_comb;
   // only clocked state uses non-blocking.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq, acc;
      sq  = a;
      acc = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] i;
      i = gf_inv(b);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
      return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [127:0] key_step_fwd(input logic [127:0] rk, input logic [3:0] i);
      logic [31:0] w0, w1, w2, w3;
      w0 = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {rcon(i), 24'h0};
      w1 = rk[95:64] ^ w0;
      w2 = rk[63:32] ^ w1;
      w3 = rk[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one forward step: rk_r -> rk_(r-1) using Rcon[r].
   function automatic logic [127:0] key_step_inv(input logic [127:0] rk, input logic [3:0] r);
      logic [31:0] w0, w1, w2, w3;
      w3 = rk[31:0]  ^ rk[63:32];
      w2 = rk[63:32] ^ rk[95:64];
      w1 = rk[95:64] ^ rk[127:96];
      w0 = rk[127:96] ^ sub_word(rot_word(w3)) ^ {rcon(r), 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
      return o;
   endfunction

   function automatic logic [31:0] col_of(input logic [127:0] x, input int c);
      return x[127-32*c -: 32];
   endfunction

endpackage

// File: rtl/aes_inv_mixcolumn32.sv
// InvMixColumns on a single 32-bit column (byte 0 in [31:24]); combinational.
module aes_inv_mixcolumn32
   import aes_pkg::*;
(
   input  logic [31:0] column,
   output logic [31:0] mixed
);

   logic [7:0] a0, a1, a2, a3;

   assign {a0, a1, a2, a3} = column;

   assign mixed[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
   assign mixed[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
   assign mixed[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
   assign mixed[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 inverse cipher, one 32-bit column per cycle, 54-cycle run.
// Round keys are walked backwards from the forward-expanded rk10.
module aes128_decrypt
   import aes_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         ce,
   input  logic [127:0] data_in,
   input  logic [127:0] key,
   output logic [127:0] data_out,
   output logic         done
);

   state_t       state, state_next;
   logic [3:0]   rnd_cnt;
   logic [1:0]   col_cnt;
   logic         last_col;
   logic [127:0] rk, src, dst, dst_next, src_isr;
   logic [31:0]  ark_col, imc_col, new_col;

   assign last_col = (col_cnt == 2'd3);
   assign src_isr  = inv_shift_rows(src);
   assign ark_col  = inv_sub_word(col_of(src_isr, int'(col_cnt))) ^ col_of(rk, int'(col_cnt));

   aes_inv_mixcolumn32 u_inv_mix (
      .column (ark_col),
      .mixed  (imc_col)
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      new_col  = ark_col;
      dst_next = dst;
      if (state == ARK0)
         new_col = col_of(src, int'(col_cnt)) ^ col_of(rk, int'(col_cnt));
      else if (state == ROUND)
         new_col = imc_col;
      for (int c = 0; c < 4; c++)
         if (c == int'(col_cnt)) dst_next[127-32*c -: 32] = new_col;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (ce) state_next = KEYEXP;
         KEYEXP:  if (ce && rnd_cnt == 4'd9) state_next = ARK0;
         ARK0:    if (ce && last_col) state_next = ROUND;
         ROUND:   if (ce && last_col && rnd_cnt == 4'd9) state_next = FINAL;
         FINAL:   if (ce && last_col) state_next = DONE;
         DONE:    if (!ce) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // rnd_cnt: KEYEXP step index 0..9; ARK0/ROUND/FINAL use round r = 10 - rnd_cnt.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         rnd_cnt  <= 4'd0;
         col_cnt  <= 2'd0;
         done     <= 1'b0;
         data_out <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               rnd_cnt <= 4'd0;
               col_cnt <= 2'd0;
            end
            KEYEXP: if (ce) rnd_cnt <= (rnd_cnt == 4'd9) ? 4'd0 : rnd_cnt + 4'd1;
            ARK0, ROUND, FINAL: if (ce) begin
               col_cnt <= col_cnt + 2'd1;
               if (last_col) begin
                  rnd_cnt <= (state == FINAL) ? 4'd0 : rnd_cnt + 4'd1;
                  if (state == FINAL) begin
                     data_out <= dst_next;
                     done     <= 1'b1;
                  end
               end
            end
            DONE: if (!ce) done <= 1'b0;
            default: ;
         endcase
      end
   end

   // NOTE: datapath registers carry no reset; each run loads them before use.
   always_ff @(posedge clock) begin
      case (state)
         IDLE: if (ce) begin
            rk  <= key;
            src <= data_in;
         end
         KEYEXP: if (ce) rk <= key_step_fwd(rk, rnd_cnt + 4'd1);
         ARK0, ROUND, FINAL: if (ce) begin
            dst <= dst_next;
            if (last_col && state != FINAL) begin
               src <= dst_next;
               rk  <= key_step_inv(rk, 4'd10 - rnd_cnt);
            end
         end
         default: ;
      endcase
   end

endmodule
